// File: rtl/stop_it_display_pkg.sv
// Shared types and constants for the Stop-It seven-segment display stage.
// The segment table is active-low with bit 0 = segment a through bit 6 = segment g.
package stop_it_display_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } phase_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Indexed by hex value; entry 0 is the rightmost element of the concatenation.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] value);
    return SEG_TABLE[value];
  endfunction

endpackage

// File: rtl/stop_it_display_if.sv
// Digit bus from the game core: four hex values plus per-digit enables.
interface stop_it_display_if;
  import stop_it_display_pkg::*;

  logic       digit0_en;
  logic       digit1_en;
  logic       digit2_en;
  logic       digit3_en;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;

  modport master (
    output digit0_en, digit1_en, digit2_en, digit3_en,
    output digit0, digit1, digit2, digit3
  );

  modport slave (
    input digit0_en, digit1_en, digit2_en, digit3_en,
    input digit0, digit1, digit2, digit3
  );

endinterface

// File: rtl/stop_it_display_hex7seg.sv
// Combinational hex to active-low seven-segment decoder.
module hex7seg
  import stop_it_display_pkg::*;
(
  input  logic [3:0] value_i,
  output logic [6:0] segments_o
);

  always_comb begin
    segments_o = seg_decode(value_i);
  end

endmodule

// File: rtl/stop_it_display.sv
// Multiplexed four-digit common-anode display driver with a blanking gap per digit
// and a once-per-frame snapshot of the digit bus so frames are never torn.
module stop_it_display
  import stop_it_display_pkg::*;
#(
  parameter int unsigned DRIVE_CYCLES = 20000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  stop_it_display_if.slave         digits,
  output logic [3:0]               anode_o,
  output logic [6:0]               segments_o
);

  localparam int unsigned MaxCycles = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] DriveLast = CntW'(DRIVE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  logic [1:0]      idx_q, idx_d;
  phase_t          phase_q, phase_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      snap_en_q;
  logic [3:0][3:0] snap_val_q;
  logic            snap_take;
  logic            lit;
  logic [6:0]      seg_dec;

  // Capture on the final blank cycle of digit 0 so the whole frame uses one snapshot.
  assign snap_take = (phase_q == BLANK) && (idx_q == 2'd0) && (cnt_q == BlankLast);

  always_comb begin
    idx_d   = idx_q;
    phase_d = phase_q;
    cnt_d   = cnt_q + CntOne;
    unique case (phase_q)
      BLANK: begin
        if (cnt_q == BlankLast) begin
          phase_d = DRIVE;
          cnt_d   = '0;
        end
      end
      DRIVE: begin
        if (cnt_q == DriveLast) begin
          phase_d = BLANK;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
        end
      end
      default: begin
        phase_d = BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q      <= 2'd0;
      phase_q    <= BLANK;
      cnt_q      <= '0;
      snap_en_q  <= '0;
      snap_val_q <= '0;
    end else begin
      idx_q   <= idx_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      if (snap_take) begin
        snap_en_q  <= {digits.digit3_en, digits.digit2_en, digits.digit1_en, digits.digit0_en};
        snap_val_q <= {digits.digit3, digits.digit2, digits.digit1, digits.digit0};
      end
    end
  end

  hex7seg u_hex7seg (
    .value_i    (snap_val_q[idx_q]),
    .segments_o (seg_dec)
  );

  always_comb begin
    lit        = (phase_q == DRIVE) && snap_en_q[idx_q];
    anode_o    = lit ? ~(4'b0001 << idx_q) : 4'hF;
    segments_o = lit ? seg_dec : SEG_OFF;
  end

endmodule

// File: tb/tb_stop_it_display.sv
// Bench for stop_it_display with DRIVE_CYCLES=4, BLANK_CYCLES=2 (24-cycle frame).
module tb_stop_it_display;

  localparam int unsigned Frame = 24;

  logic       clk;
  logic       rst;
  logic [3:0] anode;
  logic [6:0] segments;

  stop_it_display_if dig ();

  stop_it_display #(
    .DRIVE_CYCLES (4),
    .BLANK_CYCLES (2)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .digits     (dig),
    .anode_o    (anode),
    .segments_o (segments)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got anode=%h seg=%h, want anode=%h seg=%h at %0t",
               name, act[10:7], act[6:0], exp[10:7], exp[6:0], $time);
    end
  endtask

  // Model: cycles since the last reset edge, position in frame, and the frame snapshot.
  int         mc = 0;
  bit         m_live = 0;
  logic [3:0] m_en = '0;
  logic [3:0] m_val [4] = '{4'h0, 4'h0, 4'h0, 4'h0};

  always @(posedge clk) begin
    int p, slot;
    logic lit_m;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    if (rst) begin
      mc = 0;
      m_live = 1;
      m_en = '0;
      for (int i = 0; i < 4; i++) m_val[i] = 4'h0;
    end else if (m_live) begin
      mc++;
      if (mc % Frame == 2) begin
        m_en = {dig.digit3_en, dig.digit2_en, dig.digit1_en, dig.digit0_en};
        m_val[0] = dig.digit0;
        m_val[1] = dig.digit1;
        m_val[2] = dig.digit2;
        m_val[3] = dig.digit3;
      end
    end
    #1;
    if (m_live) begin
      p       = mc % Frame;
      slot    = p / 6;
      lit_m   = ((p % 6) >= 2) && m_en[slot];
      exp_an  = lit_m ? ~(4'b0001 << slot) : 4'hF;
      exp_seg = lit_m ? seg_tbl[m_val[slot]] : 7'h7F;
      check("model", {anode, segments}, {exp_an, exp_seg});
      n_cmp++;
      if ($countones(~anode) > 1) begin
        n_err++;
        $display("FAIL onehot: got anode=%h, want at most one low bit at %0t", anode, $time);
      end
    end
  end

  task automatic wait_mod(input int t);
    bit hit = 0;
    for (int k = 0; k < 3 * Frame; k++) begin
      @(negedge clk);
      if (mc % Frame == t) begin
        hit = 1;
        break;
      end
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL wait_mod: got no frame position %0d, want it within %0d cycles", t, 3 * Frame);
    end
  endtask

  // Hand-derived pattern for digits 3..0 = 8,0,F,1, indexed by cycle within the frame.
  logic [3:0] pat_an [24] = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE,
                              4'hF, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD,
                              4'hF, 4'hF, 4'hB, 4'hB, 4'hB, 4'hB,
                              4'hF, 4'hF, 4'h7, 4'h7, 4'h7, 4'h7};
  logic [6:0] pat_sg [24] = '{7'h7F, 7'h7F, 7'h79, 7'h79, 7'h79, 7'h79,
                              7'h7F, 7'h7F, 7'h0E, 7'h0E, 7'h0E, 7'h0E,
                              7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40,
                              7'h7F, 7'h7F, 7'h00, 7'h00, 7'h00, 7'h00};

  initial begin
    rst = 1'b1;
    dig.digit0_en = 1'b1;
    dig.digit1_en = 1'b1;
    dig.digit2_en = 1'b1;
    dig.digit3_en = 1'b1;
    dig.digit0 = 4'h1;
    dig.digit1 = 4'hF;
    dig.digit2 = 4'h0;
    dig.digit3 = 4'h8;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_dark", {anode, segments}, {4'hF, 7'h7F});
    end
    rst = 1'b0;

    for (int j = 0; j < 2 * Frame; j++) begin
      if (j > 0) @(negedge clk);
      check("pattern", {anode, segments}, {pat_an[j % Frame], pat_sg[j % Frame]});
    end

    // Disabled digit 2 keeps its slot but stays dark.
    dig.digit2_en = 1'b0;
    wait_mod(0);
    wait_mod(15);
    check("dis_slot", {anode, segments}, {4'hF, 7'h7F});
    wait_mod(21);
    check("dis_d3", {anode, segments}, {4'h7, 7'h00});
    dig.digit2_en = 1'b1;

    // Mid-frame change only shows from the next frame.
    wait_mod(9);
    dig.digit3 = 4'h2;
    wait_mod(20);
    check("tear_old", {anode, segments}, {4'h7, 7'h00});
    wait_mod(20);
    check("tear_new", {anode, segments}, {4'h7, 7'h24});

    // One-cycle reset during digit 2 drive.
    wait_mod(15);
    rst = 1'b1;
    @(negedge clk);
    check("rst_dark", {anode, segments}, {4'hF, 7'h7F});
    rst = 1'b0;
    @(negedge clk);
    check("rst_blank", {anode, segments}, {4'hF, 7'h7F});
    @(negedge clk);
    check("rst_d0", {anode, segments}, {4'hE, 7'h79});

    // Sweep digit 0 through all 16 values, one per frame.
    for (int v = 0; v < 16; v++) begin
      wait_mod(12);
      dig.digit0 = 4'(v);
      wait_mod(3);
      check("sweep", {anode, segments}, {4'hE, seg_tbl[v]});
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
